seg_scan_capture: RTL and testbench

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_scan_capture_if.sv | 20 ++
 rtl/seg_scan_capture.sv | 150 +++++++++++++++
 tb/tb_seg_scan_capture.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_capture_if.sv
// Signal bundle for seg_scan_capture: the multiplexed display bus in, the report handshake out.
interface seg_scan_capture_if;
    logic [6:0] seg_in;
    logic [3:0] an_in;
    logic [6:0] out_seg;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    modport slave (
        input  seg_in, an_in, out_ready,
        output out_seg, out_idx, out_valid, overflow
    );

    modport master (
        output seg_in, an_in, out_ready,
        input  out_seg, out_idx, out_valid, overflow
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed 4-digit 7-segment bus once per anode dwell and reports each digit's stable pattern.
// Optional macro SEG_SCAN_CAPTURE_BLANK_FILTER_EN suppresses reports of the all-off pattern (7'h7F).
module seg_scan_capture #(
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_capture_if.slave  bus
);
    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);
    localparam logic [2:0] LP_STABLE = 3'(STABLE_CNT);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_an, w_an_nxt;
    logic       w_sample;
    logic       w_an_ok;
    logic       w_an_chg;
    logic [1:0] w_idx;

    logic [6:0] r_cand [4];
    logic [2:0] r_mcnt [4];
    logic [6:0] r_last [4];
    logic [3:0] r_rep;

    logic [6:0] r_seg;
    logic [1:0] r_idx;
    logic       r_valid;
    logic       r_ovf;

    logic [2:0] w_mcnt_new;
    logic       w_event;
    logic       w_load;

    assign w_an_ok  = $onehot(~bus.an_in);
    assign w_an_chg = (bus.an_in != r_an);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_an    <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_an    <= w_an_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_an_nxt    = r_an;
        w_sample    = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_an_ok) begin
                w_state_nxt = S_SETTLE;
                w_cnt_nxt   = LP_SETTLE;
                w_an_nxt    = bus.an_in;
            end
        end else if (w_an_chg) begin
            // Any anode change aborts the dwell, including a pending sample.
            w_an_nxt    = bus.an_in;
            w_state_nxt = w_an_ok ? S_SETTLE : S_IDLE;
            w_cnt_nxt   = LP_SETTLE;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    if (r_cnt <= 4'd1) w_state_nxt = S_SAMPLE;
                    else               w_cnt_nxt   = r_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        case (~r_an)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_comb begin
        if (bus.seg_in != r_cand[w_idx])   w_mcnt_new = 3'd1;
        else if (r_mcnt[w_idx] >= LP_STABLE) w_mcnt_new = LP_STABLE;
        else                                w_mcnt_new = r_mcnt[w_idx] + 3'd1;
    end

    // Re-armed by comparing against last-reported, so a dropped report retries on the next stable sample.
`ifdef SEG_SCAN_CAPTURE_BLANK_FILTER_EN
    assign w_event = w_sample && (w_mcnt_new == LP_STABLE) && (bus.seg_in != 7'h7F) &&
                     (!r_rep[w_idx] || (bus.seg_in != r_last[w_idx]));
`else
    assign w_event = w_sample && (w_mcnt_new == LP_STABLE) &&
                     (!r_rep[w_idx] || (bus.seg_in != r_last[w_idx]));
`endif
    assign w_load = w_event && (!r_valid || bus.out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_cand[i] <= '1;
                r_mcnt[i] <= '0;
                r_last[i] <= '1;
            end
            r_rep <= '0;
        end else begin
            if (w_sample) begin
                r_cand[w_idx] <= bus.seg_in;
                r_mcnt[w_idx] <= w_mcnt_new;
            end
            if (w_load) begin
                r_rep[w_idx]  <= 1'b1;
                r_last[w_idx] <= bus.seg_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= '1;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_seg   <= bus.seg_in;
            r_idx   <= w_idx;
            r_valid <= 1'b1;
        end else if (w_event) begin
            r_ovf   <= 1'b1;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_seg   = r_seg;
    assign bus.out_idx   = r_idx;
    assign bus.out_valid = r_valid;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: directed scan sequences push expected reports, a monitor pops and compares.
module tb_seg_scan_capture;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_capture_if bus();

    seg_scan_capture #(.SETTLE(4), .STABLE_CNT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [6:0] seg;
    } rep_t;

    rep_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] pat [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] idx, input logic [6:0] seg);
        rep_t r;
        r.idx = idx;
        r.seg = seg;
        q.push_back(r);
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input int rounds);
        logic [3:0] a;
        for (int r = 0; r < rounds; r++) begin
            for (int d = 0; d < 4; d++) begin
                a = 4'b0001 << d;
                a = ~a;
                dwell(a, pat[d], 8);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        rep_t e;
        rst           = 1'b1;
        bus.an_in     = 4'hF;
        bus.seg_in    = 7'h7F;
        bus.out_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.out_valid) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_report: got idx=%0d seg=%h, required no report (t=%0t)",
                                 bus.out_idx, bus.out_seg, $time);
                    end else if (bus.out_ready) begin
                        e = q.pop_front();
                        chk("report_idx", bus.out_idx, e.idx);
                        chk("report_seg", bus.out_seg, e.seg);
                    end else begin
                        chk("held_idx", bus.out_idx, q[0].idx);
                        chk("held_seg", bus.out_seg, q[0].seg);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_seg", bus.out_seg, 7'h7F);
        chk("rst_idx", bus.out_idx, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst = 1'b0;

        // Every digit shows 7'h40; each reports after its third dwell.
        for (int d = 0; d < 4; d++) pat[d] = 7'h40;
        for (int d = 0; d < 4; d++) push(2'(d), 7'h40);
        scan(3);
        drain();

        // Unchanged input: nothing further.
        scan(2);
        drain();

        // Digit 0 changes to 7'h79.
        pat[0] = 7'h79;
        push(2'd0, 7'h79);
        scan(3);
        drain();

        // Consumer stalls: digit 0 held, digit 1 dropped.
        bus.out_ready = 1'b0;
        pat[0] = 7'h11;
        pat[1] = 7'h22;
        push(2'd0, 7'h11);
        scan(3);
        chk("held_valid", bus.out_valid, 1);
        chk("ovf_set", bus.overflow, 1);
        bus.out_ready = 1'b1;
        push(2'd1, 7'h22);
        scan(1);
        drain();

        // Invalid anodes and a short dwell carry a foreign pattern that must never be sampled.
        push(2'd2, 7'h33);
        dwell(4'b1011, 7'h33, 8);
        dwell(4'b1100, 7'h55, 10);
        dwell(4'b1011, 7'h33, 8);
        dwell(4'b1111, 7'h55, 10);
        dwell(4'b1101, 7'h22, 8);
        dwell(4'b1011, 7'h55, 3);
        dwell(4'b1101, 7'h22, 8);
        dwell(4'b1011, 7'h33, 8);
        drain();

        // Blank digit 2.
        pat[2] = 7'h7F;
`ifndef SEG_SCAN_CAPTURE_BLANK_FILTER_EN
        push(2'd2, 7'h7F);
`endif
        scan(3);
        drain();
        chk("ovf_sticky", bus.overflow, 1);

        // Reset while a report is held and a dwell is mid-settle.
        bus.out_ready = 1'b0;
        pat[3] = 7'h66;
        push(2'd3, 7'h66);
        scan(3);
        chk("held_valid2", bus.out_valid, 1);
        dwell(4'b1110, 7'h11, 2);
        #2 rst = 1'b1;
        #1;
        q.delete();
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_seg", bus.out_seg, 7'h7F);
        chk("rst2_idx", bus.out_idx, 0);
        chk("rst2_ovf", bus.overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Reported flags were cleared: digit 0 re-reports its earlier pattern.
        for (int d = 0; d < 4; d++) pat[d] = 7'h11;
        for (int d = 0; d < 4; d++) push(2'(d), 7'h11);
        scan(3);
        drain();
        chk("ovf_final", bus.overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
